// File: rtl/cpu_run_controller.sv
`timescale 1ns/1ps
// Run/step/breakpoint controller: debounces the board buttons in the clk domain and
// drives the processor clock-enable through HALT, STEP, RUN and BREAK.

module cpu_run_debounce #(
    parameter int STABLE_SAMPLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn,
    output logic press
);

    localparam int AGR_W = $clog2(STABLE_SAMPLES + 1);
    localparam logic [AGR_W-1:0] AGREE_LAST = AGR_W'(STABLE_SAMPLES - 1);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic [AGR_W-1:0] agree;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            agree  <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            if (tick) begin
                if (sync2 != stable) begin
                    // Accept the new level on the sample that completes the agreeing run.
                    if (agree == AGREE_LAST) begin
                        stable <= sync2;
                        agree  <= '0;
                        press  <= sync2;
                    end else begin
                        agree <= agree + 1'b1;
                    end
                end else begin
                    agree <= '0;
                end
            end
        end
    end

endmodule

module cpu_run_controller #(
    parameter int CLK_DIV        = 25000,
    parameter int STABLE_SAMPLES = 4,
    parameter int PC_W           = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            btn_step,
    input  logic            btn_run,
    input  logic            btn_halt,
    input  logic            bp_en,
    input  logic [PC_W-1:0] bp_addr,
    input  logic [PC_W-1:0] pc,
    output logic            cpu_en,
    output logic [1:0]      state,
    output logic            halted_at_bp
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    localparam logic [1:0] ST_HALT  = 2'b00;
    localparam logic [1:0] ST_STEP  = 2'b01;
    localparam logic [1:0] ST_RUN   = 2'b10;
    localparam logic [1:0] ST_BREAK = 2'b11;

    logic [CNT_W-1:0] tick_cnt;
    logic             tick;
    logic             ev_step_raw;
    logic             ev_run_raw;
    logic             ev_halt;
    logic             ev_step;
    logic             ev_run;
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic             bp_skip;
    logic             bp_hit;

    assign tick = (tick_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    cpu_run_debounce #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_deb_step (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .btn   (btn_step),
        .press (ev_step_raw)
    );

    cpu_run_debounce #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_deb_run (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .btn   (btn_run),
        .press (ev_run_raw)
    );

    cpu_run_debounce #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_deb_halt (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .btn   (btn_halt),
        .press (ev_halt)
    );

    // Halt outranks step, step outranks run; losers in the same cycle are dropped.
    assign ev_step = ev_step_raw & ~ev_halt;
    assign ev_run  = ev_run_raw & ~ev_halt & ~ev_step_raw;

    // The skip flag lets the breakpoint instruction itself execute once on resume.
    assign bp_hit = bp_en & (pc == bp_addr) & ~bp_skip;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cpu_en  = 1'b0;
        case (state_q)
            ST_HALT: begin
                if (ev_step) begin
                    state_d = ST_STEP;
                end else if (ev_run) begin
                    state_d = ST_RUN;
                end
            end
            ST_STEP: begin
                cpu_en  = 1'b1;
                state_d = ST_HALT;
            end
            ST_RUN: begin
                cpu_en = ~bp_hit & ~ev_halt;
                if (ev_halt) begin
                    state_d = ST_HALT;
                end else if (bp_hit) begin
                    state_d = ST_BREAK;
                end
            end
            default: begin
                if (ev_halt) begin
                    state_d = ST_HALT;
                end else if (ev_step) begin
                    state_d = ST_STEP;
                end else if (ev_run) begin
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_HALT;
            bp_skip <= 1'b0;
        end else begin
            state_q <= state_d;
            bp_skip <= (state_q == ST_BREAK) && (state_d == ST_RUN);
        end
    end

    assign state        = state_q;
    assign halted_at_bp = (state_q == ST_BREAK);

endmodule

// File: tb/tb_cpu_run_controller.sv
`timescale 1ns/1ps
// Self-checking bench for cpu_run_controller: a cycle-level behavioural model compared
// every clock, plus directed scenarios with hand-computed expectations.

module tb_cpu_run_controller;

    localparam int CLK_DIV = 4;
    localparam int STABLE  = 3;
    localparam int PC_W    = 32;
    localparam int LOG_N   = 8192;

    localparam logic [1:0] HALT = 2'b00;
    localparam logic [1:0] STEP = 2'b01;
    localparam logic [1:0] RUN  = 2'b10;
    localparam logic [1:0] BRK  = 2'b11;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            btn_step = 1'b0;
    logic            btn_run = 1'b0;
    logic            btn_halt = 1'b0;
    logic            bp_en = 1'b0;
    logic [PC_W-1:0] bp_addr = '0;
    logic [PC_W-1:0] pc = '0;
    logic            cpu_en;
    logic [1:0]      state;
    logic            halted_at_bp;
    logic            pc_clear = 1'b1;

    cpu_run_controller #(
        .CLK_DIV        (CLK_DIV),
        .STABLE_SAMPLES (STABLE),
        .PC_W           (PC_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_step     (btn_step),
        .btn_run      (btn_run),
        .btn_halt     (btn_halt),
        .bp_en        (bp_en),
        .bp_addr      (bp_addr),
        .pc           (pc),
        .cpu_en       (cpu_en),
        .state        (state),
        .halted_at_bp (halted_at_bp)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Processor stand-in: PC advances by one instruction on each enabled edge.
    always @(posedge clk) begin
        if (pc_clear) pc <= '0;
        else if (cpu_en) pc <= pc + 32'd4;
    end

    int cyc = 0;
    always @(posedge clk) begin
        if (!rst) cyc <= 0;
        else cyc <= cyc + 1;
    end

    int              en_count = 0;
    logic [31:0]     en_pcs[$];
    always @(negedge clk) begin
        if (rst && cpu_en) begin
            en_count <= en_count + 1;
            en_pcs.push_back(pc);
        end
    end

    // Behavioural model. Edge k after reset release: buttons seen through a 2-edge delay,
    // sampled when k is a multiple of CLK_DIV; events act on the following edge.
    logic [2:0] btn_log [LOG_N];
    logic [1:0] m_state = HALT;
    logic       m_skip = 1'b0;
    logic [2:0] m_ev = '0;
    logic [2:0] m_stable = '0;
    int         m_agree [3];

    function automatic logic [2:0] model_sample(input int k);
        return (k >= 3) ? btn_log[(k - 2) % LOG_N] : 3'b000;
    endfunction

    function automatic logic model_hit();
        return bp_en && (pc == bp_addr) && !m_skip;
    endfunction

    function automatic logic [1:0] model_next();
        case (m_state)
            HALT:    return m_ev[2] ? HALT : m_ev[0] ? STEP : m_ev[1] ? RUN : HALT;
            STEP:    return HALT;
            RUN:     return m_ev[2] ? HALT : model_hit() ? BRK : RUN;
            default: return m_ev[2] ? HALT : m_ev[0] ? STEP : m_ev[1] ? RUN : BRK;
        endcase
    endfunction

    function automatic logic model_cpu_en();
        case (m_state)
            STEP:    return 1'b1;
            RUN:     return !model_hit() && !m_ev[2];
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_state  <= HALT;
            m_skip   <= 1'b0;
            m_ev     <= '0;
            m_stable <= '0;
            for (int b = 0; b < 3; b++) m_agree[b] <= 0;
        end else begin
            m_state <= model_next();
            m_skip  <= (m_state == BRK) && (model_next() == RUN);
            btn_log[(cyc + 1) % LOG_N] <= {btn_halt, btn_run, btn_step};
            for (int b = 0; b < 3; b++) begin
                m_ev[b] <= 1'b0;
                if ((cyc + 1) % CLK_DIV == 0) begin
                    if (model_sample(cyc + 1)[b] != m_stable[b]) begin
                        if (m_agree[b] + 1 == STABLE) begin
                            m_stable[b] <= model_sample(cyc + 1)[b];
                            m_agree[b]  <= 0;
                            m_ev[b]     <= model_sample(cyc + 1)[b];
                        end else begin
                            m_agree[b] <= m_agree[b] + 1;
                        end
                    end else begin
                        m_agree[b] <= 0;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        check("cmp_state", 32'(state), 32'(m_state));
        check("cmp_cpu_en", 32'(cpu_en), 32'(model_cpu_en()));
        check("cmp_halted_at_bp", 32'(halted_at_bp), 32'(m_state == BRK));
    end

    initial begin
        int         t0;
        int         lat;
        int         en0;
        logic [1:0] prev_state;
        logic       prev_en;
        logic       seen;

        repeat (5) @(negedge clk);
        #1;
        check("rst_state", 32'(state), 32'(HALT));
        check("rst_cpu_en", 32'(cpu_en), 32'd0);
        check("rst_halted_at_bp", 32'(halted_at_bp), 32'd0);
        rst = 1'b1;
        pc_clear = 1'b0;

        // Idle: nothing may happen without a button.
        repeat (1000) @(negedge clk);
        #1;
        check("t1_state", 32'(state), 32'(HALT));
        check("t1_en_count", 32'(en_count), 32'd0);

        // Single step, pressed just before a known tick phase.
        while (cyc % CLK_DIV != 3) @(negedge clk);
        t0 = cyc;
        en0 = en_count;
        lat = -1;
        btn_step = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cpu_en && lat < 0) lat = cyc - t0;
        end
        btn_step = 1'b0;
        #1;
        check("t2_pulses", 32'(en_count - en0), 32'd1);
        check("t2_latency_window", 32'(lat >= 14 && lat <= 18), 32'd1);
        check("t2_state", 32'(state), 32'(HALT));
        check("t2_pc", pc, 32'h4);
        repeat (30) @(negedge clk);

        // Bouncing run button never holds for three samples.
        en0 = en_count;
        for (int i = 0; i < 60; i++) begin
            btn_run = ((i / 3) % 2 == 0);
            @(negedge clk);
        end
        btn_run = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        check("t3_en_count", 32'(en_count - en0), 32'd0);
        check("t3_state", 32'(state), 32'(HALT));

        // Run into a breakpoint at 0x10.
        pc_clear = 1'b1;
        @(negedge clk);
        pc_clear = 1'b0;
        bp_en = 1'b1;
        bp_addr = 32'h10;
        en_pcs.delete();
        btn_run = 1'b1;
        repeat (25) @(negedge clk);
        btn_run = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check("t4_state", 32'(state), 32'(BRK));
        check("t4_halted_at_bp", 32'(halted_at_bp), 32'd1);
        check("t4_cpu_en", 32'(cpu_en), 32'd0);
        check("t4_pc", pc, 32'h10);
        check("t4_en_count", 32'(en_pcs.size()), 32'd4);
        for (int i = 0; i < 4 && i < en_pcs.size(); i++) check("t4_en_pc", en_pcs[i], 32'(4 * i));

        // Resume: the breakpoint instruction executes once, then halt.
        en_pcs.delete();
        btn_run = 1'b1;
        repeat (25) @(negedge clk);
        btn_run = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("t5_state_run", 32'(state), 32'(RUN));
        check("t5_resumed", 32'(en_pcs.size() >= 2), 32'd1);
        if (en_pcs.size() >= 2) begin
            check("t5_first_pc", en_pcs[0], 32'h10);
            check("t5_second_pc", en_pcs[1], 32'h14);
        end
        seen = 1'b0;
        prev_state = state;
        prev_en = cpu_en;
        btn_halt = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 24) btn_halt = 1'b0;
            if (prev_state == RUN && state == HALT) begin
                seen = 1'b1;
                check("t5_halt_cycle_cpu_en", 32'(prev_en), 32'd0);
            end
            prev_state = state;
            prev_en = cpu_en;
        end
        #1;
        check("t5_halt_seen", 32'(seen), 32'd1);
        check("t5_state_halt", 32'(state), 32'(HALT));

        // Simultaneous halt and run: halt wins, nothing runs.
        bp_en = 1'b0;
        en0 = en_count;
        btn_halt = 1'b1;
        btn_run = 1'b1;
        repeat (25) @(negedge clk);
        btn_halt = 1'b0;
        btn_run = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        check("t6_en_count", 32'(en_count - en0), 32'd0);
        check("t6_state", 32'(state), 32'(HALT));

        // Reset while running drops the enable immediately.
        btn_run = 1'b1;
        repeat (25) @(negedge clk);
        #1;
        check("t6_run_state", 32'(state), 32'(RUN));
        @(negedge clk);
        rst = 1'b0;
        btn_run = 1'b0;
        #1;
        check("t6_rst_cpu_en", 32'(cpu_en), 32'd0);
        check("t6_rst_state", 32'(state), 32'(HALT));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        en0 = en_count;
        repeat (40) @(negedge clk);
        #1;
        check("t6_after_rst_state", 32'(state), 32'(HALT));
        check("t6_after_rst_en", 32'(en_count - en0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
